// File: rtl/switch_move_controller.sv
// switch_move_controller
// Conditions the four raw board switches into debounced levels, one-per-press
// move commands on a valid/ready handshake, and a single game_reset pulse
// when all four switches are held as a chord.
// Optional build macro AUTO_REPEAT_EN adds an auto-repeat timer for a single
// held direction.
module switch_move_controller #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int CHORD_HOLD_CYCLES = 12500000,
  parameter int REPEAT_CYCLES     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       game_reset,
  output logic [3:0] held
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int CH_W = (CHORD_HOLD_CYCLES > 1) ? $clog2(CHORD_HOLD_CYCLES) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHORD_HOLD_CYCLES - 1);
  localparam logic [3:0] ALL_ON = 4'b1111;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHORD_WAIT = 2'd1,
    CHORD_LOCK = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      sync_p0;
  logic [3:0]      sync_p1;
  logic [3:0]      held_p2;
  logic [DB_W-1:0] db_cnt [4];
  logic [CH_W-1:0] chord_cnt;
  logic [3:0]      rise;
  logic [3:0]      rep_vec;
  logic [3:0]      req_vec;
  logic [1:0]      req_dir;
  logic            req_ok;
  logic            enter_chord;

  // Stage p0/p1: two-flop synchronizer on the asynchronous switch pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 4'b0000;
      sync_p1 <= 4'b0000;
    end else begin
      sync_p0 <= {switch4, switch3, switch2, switch1};
      sync_p1 <= sync_p0;
    end
  end

  // Stage p1 -> held: per-switch debounce; the counter never passes DB_LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= 4'b0000;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == held[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          held[i]   <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage p2: previous debounced level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) held_p2 <= 4'b0000;
    else       held_p2 <= held;
  end

  assign rise        = held & ~held_p2;
  assign enter_chord = (state == IDLE) && (held == ALL_ON);
  assign req_ok      = (state == IDLE) && (held != ALL_ON);

`ifdef AUTO_REPEAT_EN
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rep_cnt;
  logic            rep_active;

  // Timer only runs while exactly one direction has been steadily held in IDLE
  assign rep_active = (state == IDLE) && (held == held_p2) && (held != 4'b0000) &&
                      ((held & (held - 4'd1)) == 4'b0000);

  // Repeat timer: restarts on every held change, on leaving IDLE, and after each fire
  always_ff @(posedge clk) begin
    if (reset)                   rep_cnt <= '0;
    else if (!rep_active)        rep_cnt <= '0;
    else if (rep_cnt == RP_LAST) rep_cnt <= '0;
    else                         rep_cnt <= rep_cnt + 1'b1;
  end

  assign rep_vec = (rep_active && (rep_cnt == RP_LAST)) ? held : 4'b0000;
`else
  // No auto-repeat: the interval parameter only shapes this constant tie-off
  assign rep_vec = 4'b0000 & {4{REPEAT_CYCLES > 0}};
`endif

  assign req_vec = rise | rep_vec;

  // Fixed priority up > down > left > right; lower requests are dropped
  always_comb begin
    req_dir = 2'd0;
    if      (req_vec[0]) req_dir = 2'd0;
    else if (req_vec[1]) req_dir = 2'd1;
    else if (req_vec[2]) req_dir = 2'd2;
    else if (req_vec[3]) req_dir = 2'd3;
  end

  // Single-entry move buffer; requests arriving while busy are discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      move_valid <= 1'b0;
      move_dir   <= 2'd0;
    end else if (enter_chord) begin
      move_valid <= 1'b0;
    end else if (move_valid && move_ready) begin
      move_valid <= 1'b0;
    end else if (!move_valid && req_ok && (req_vec != 4'b0000)) begin
      move_valid <= 1'b1;
      move_dir   <= req_dir;
    end
  end

  // Chord hold timer: zero outside CHORD_WAIT, saturates at CH_LAST
  always_ff @(posedge clk) begin
    if (reset)                      chord_cnt <= '0;
    else if (state != CHORD_WAIT)   chord_cnt <= '0;
    else if (chord_cnt != CH_LAST)  chord_cnt <= chord_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and the game_reset pulse
  always_comb begin
    state_nxt  = state;
    game_reset = 1'b0;
    case (state)
      IDLE: begin
        if (held == ALL_ON) state_nxt = CHORD_WAIT;
      end
      CHORD_WAIT: begin
        if (held != ALL_ON) begin
          state_nxt = IDLE;
        end else if (chord_cnt == CH_LAST) begin
          game_reset = 1'b1;
          state_nxt  = CHORD_LOCK;
        end
      end
      CHORD_LOCK: begin
        if (held == 4'b0000) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
